// File: rtl/mini_src_control_unit.sv
// ---------------------------------------------------------------------------
// mini_src_control_unit
//
// Hardwired Moore control unit for the Mini SRC datapath. It runs the
// instruction fetch (T0-T2) and then executes three-register ALU instructions,
// plus MUL/DIV when the optional build macro is defined. The datapath strobes
// come from a combinational decode of the state register and IR_Data.
//
// Build option:
//   CTRL_MULDIV_EN  defined   -> MUL (01111) and DIV (10000) run T3..T6
//                   undefined -> no T6 state; HI_in/LO_in/Zhigh_out are
//                                tied to 0; 01111/10000 trap as illegal
//
// Ports:
//   clk              system clock, rising edge
//   clr              asynchronous active-high reset
//   run              level request to execute (sampled in IDLE and HALT)
//   IR_Data[31:0]    instruction register contents from the datapath
//   PC_out .. LO_in  single-bit datapath strobes
//   R_in[15:0]       one-hot general register load enable
//   R_out[15:0]      one-hot general register bus drive
//   alu_instruction  ALU operation select (nonzero only in T4)
//   halted           state is HALT
//   illegal          sticky illegal-opcode flag
//   retired          wrapping count of completed instructions
// ---------------------------------------------------------------------------
module mini_src_control_unit #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [31:0]         IR_Data,
  output logic                PC_out,
  output logic                PC_in,
  output logic                IncPC,
  output logic                MAR_in,
  output logic                MDR_in,
  output logic                MDR_out,
  output logic                Read,
  output logic                IR_in,
  output logic                Y_in,
  output logic                Z_in,
  output logic                Zlow_out,
  output logic                Zhigh_out,
  output logic                HI_in,
  output logic                LO_in,
  output logic [15:0]         R_in,
  output logic [15:0]         R_out,
  output logic [4:0]          alu_instruction,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
`ifdef CTRL_MULDIV_EN
    S_T6   = 4'd7,
`endif
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01100;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_NOP    = 5'b11010;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  state_t                state_q, state_d;
  logic                  illegal_q, illegal_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  // IR field extraction
  logic [4:0] op_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       is_alu_s, is_muldiv_s, is_nop_s, is_halt_s;
  logic       unused_ir_s;

  assign op_s = IR_Data[31:27];
  assign ra_s = IR_Data[26:23];
  assign rb_s = IR_Data[22:19];
  assign rc_s = IR_Data[18:15];

  // Low IR bits (immediates, unused here) are deliberately ignored.
  assign unused_ir_s = ^IR_Data[14:0];

  assign is_alu_s = (op_s >= OP_ALU_LO) && (op_s <= OP_ALU_HI);
`ifdef CTRL_MULDIV_EN
  assign is_muldiv_s = (op_s == OP_MUL) || (op_s == OP_DIV);
`else
  assign is_muldiv_s = 1'b0;
`endif
  assign is_nop_s  = (op_s == OP_NOP);
  assign is_halt_s = (op_s == OP_HALT);

  // State, sticky illegal flag and retire counter registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, illegal flag and retire counter update
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_T0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        // IR holds the new instruction from T3 on, so branching happens here.
        if (is_alu_s || is_muldiv_s) begin
          state_d = S_T4;
        end else if (is_nop_s) begin
          state_d   = S_T0;
          retired_d = retired_q + RETIRE_W'(1);
        end else if (is_halt_s) begin
          state_d   = S_HALT;
          retired_d = retired_q + RETIRE_W'(1);
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
`ifdef CTRL_MULDIV_EN
        if (is_muldiv_s) begin
          state_d = S_T6;
        end else begin
          state_d   = S_T0;
          retired_d = retired_q + RETIRE_W'(1);
        end
`else
        state_d   = S_T0;
        retired_d = retired_q + RETIRE_W'(1);
`endif
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        state_d   = S_T0;
        retired_d = retired_q + RETIRE_W'(1);
      end
`endif
      S_HALT: begin
        // Restart needs run to drop first, so a held run does not re-launch.
        if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state and IR fields
  always_comb begin
    PC_out          = 1'b0;
    PC_in           = 1'b0;
    IncPC           = 1'b0;
    MAR_in          = 1'b0;
    MDR_in          = 1'b0;
    MDR_out         = 1'b0;
    Read            = 1'b0;
    IR_in           = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    Zlow_out        = 1'b0;
    Zhigh_out       = 1'b0;
    HI_in           = 1'b0;
    LO_in           = 1'b0;
    R_in            = 16'h0000;
    R_out           = 16'h0000;
    alu_instruction = 5'b00000;
    case (state_q)
      S_T0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
      end
      S_T1: begin
        Zlow_out = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
      end
      S_T3: begin
        if (is_alu_s) begin
          R_out = 16'h0001 << rb_s;
          Y_in  = 1'b1;
        end else if (is_muldiv_s) begin
          R_out = 16'h0001 << ra_s;
          Y_in  = 1'b1;
        end else begin
          R_out = 16'h0000;
        end
      end
      S_T4: begin
        if (is_alu_s) begin
          R_out           = 16'h0001 << rc_s;
          alu_instruction = op_s;
          Z_in            = 1'b1;
        end else if (is_muldiv_s) begin
          R_out           = 16'h0001 << rb_s;
          alu_instruction = op_s;
          Z_in            = 1'b1;
        end else begin
          R_out = 16'h0000;
        end
      end
      S_T5: begin
        Zlow_out = 1'b1;
        if (is_muldiv_s) begin
          LO_in = 1'b1;
        end else begin
          R_in = 16'h0001 << ra_s;
        end
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        Zhigh_out = 1'b1;
        HI_in     = 1'b1;
      end
`endif
      default: begin
        PC_out = 1'b0;
      end
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: doc/mini_src_control_unit.md
# mini_src_control_unit

Hardwired Moore control unit for the Mini SRC datapath. Sequences instruction fetch (T0–T2) and execution of three-register ALU instructions, and with the configuration macro also MUL/DIV, by driving the datapath's register-enable, bus-select, memory-read and ALU-select lines one state per clock. It replaces hand-driven control sequences and sits beside `datapath`, reading `IR_Data` back from it. It also provides a run/halt handshake, an illegal-opcode trap and a retired-instruction counter.

## Interface
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: system clock; all state changes on the rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `run` in 1: level request to execute; sampled in IDLE.
- `IR_Data` in 32: current IR contents from the datapath.
- `PC_out`, `PC_in`, `IncPC`, `MAR_in`, `MDR_in`, `MDR_out`, `Read`, `IR_in`, `Y_in`, `Z_in`, `Zlow_out`, `Zhigh_out`, `HI_in`, `LO_in` out 1 each: datapath strobes.
- `R_in` out 16: one-hot general-register load enable.
- `R_out` out 16: one-hot general-register bus drive.
- `alu_instruction` out 5: ALU operation select.
- `halted` out 1: state is HALT.
- `illegal` out 1: sticky illegal-opcode flag.
- `retired` out RETIRE_W: count of completed instructions.

## Operation
- IR fields:
  - `op` = IR[31:27]
  - `ra` = IR[26:23]
  - `rb` = IR[22:19]
  - `rc` = IR[18:15]
- Decoded classes:
  - ALU: `op` in 00011..01100 (add, sub, and, or, shr, shra, shl, ror, rol, …).
  - MULDIV: 01111 (mul), 10000 (div); present only when enabled.
  - NOP: 11010.
  - HALT: 11011.
  - Everything else is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are a combinational decode of the state register and `IR_Data`. Any strobe not listed for a state is 0, `R_in`/`R_out` are 0, and `alu_instruction` is 0.
  - T0: `PC_out`, `MAR_in`, `IncPC`, `Z_in`.
  - T1: `Zlow_out`, `PC_in`, `Read`, `MDR_in`.
  - T2: `MDR_out`, `IR_in`.
  - T3, ALU class: `R_out[rb]`, `Y_in`.
  - T3, MULDIV class: `R_out[ra]`, `Y_in`.
  - T4, ALU class: `R_out[rc]`, `alu_instruction` = `op`, `Z_in`.
  - T4, MULDIV class: `R_out[rb]`, `alu_instruction` = `op`, `Z_in`.
  - T5, ALU class: `Zlow_out`, `R_in[ra]`.
  - T5, MULDIV class: `Zlow_out`, `LO_in`.
  - T6 (MULDIV only): `Zhigh_out`, `HI_in`.
- Transitions:
  - IDLE → T0 when `run`=1, else stay in IDLE.
  - T0 → T1 → T2 → T3 unconditionally.
  - At T3, branch on `op` (IR is valid from T3 onward):
    - ALU class: T3 → T4 → T5 → T0.
    - MULDIV class: T3 → T4 → T5 → T6 → T0.
    - NOP: T3 → T0, with no strobes asserted in T3.
    - HALT opcode: T3 → HALT.
    - Illegal opcode: T3 → HALT and set `illegal`.
  - HALT → IDLE when `run`=0, else stay in HALT. Restarting after a halt therefore requires `run` to drop and rise again.
- `retired` increments by 1 on the clock edge that leaves the final state of each instruction:
  - ALU: T5.
  - MULDIV: T6.
  - NOP or HALT opcode: T3.
  - An illegal opcode does not increment the counter.
  - The counter wraps from all-ones to 0.
- `illegal` clears only on `clr`.

## Timing
- On `clr`=1, asynchronously: state = IDLE, `illegal`=0, `retired`=0. All strobes, `R_in`, `R_out` and `alu_instruction` are 0, and `halted`=0.
- Each state lasts exactly one clock.
- Fetch takes 3 cycles.
- Total cycles per instruction from T0: ALU 6, MULDIV 7, NOP 4, HALT opcode 4 then HALT.
- `run` in IDLE is seen on the next rising edge; T0 is entered one cycle after `run` is sampled high.
- A `clr` asserted in any state aborts the instruction immediately. No strobe remains asserted after `clr` goes high.
- `R_in` and `R_out` are never both nonzero. At most one bit of each is set.
- `alu_instruction` is nonzero only in T4.

## Configuration
- `CTRL_MULDIV_EN` defined: MULDIV opcodes 01111 and 10000 follow T3–T6 as specified above.
- `CTRL_MULDIV_EN` undefined: state T6 and `HI_in`/`LO_in` logic are removed. `HI_in`, `LO_in` and `Zhigh_out` are tied to 0, and opcodes 01111/10000 are treated as illegal (T3 → HALT, `illegal`=1).

## Test plan
- Reset: assert `clr` for 2 cycles, then release with `run`=0 → state stays IDLE, all outputs 0, `retired`=0.
- ALU instruction: `run`=1, `IR_Data`=0x389A8000 (shr R1,R3,R5) → the following cycles show:
  - T3: `R_out`=0x0008, `Y_in`=1.
  - T4: `R_out`=0x0020, `alu_instruction`=00111, `Z_in`=1.
  - T5: `R_in`=0x0002, `Zlow_out`=1.
  - T0 follows, and `retired`=1.
- MULDIV instruction: `IR_Data`=0x78980000 (mul R3,R1) with `CTRL_MULDIV_EN` defined → T3 `R_out`=0x0002, T4 `R_out`=0x0008, T5 `LO_in`=1, T6 `HI_in`=1 with `Zhigh_out`=1. Repeat undefined → HALT with `illegal`=1.
- NOP then HALT: NOP (0xD0000000) → 4 cycles, `retired`+1. HALT (0xD8000000) → `halted`=1. `run` held 1 keeps HALT; `run`=0 → IDLE; `run`=1 → T0.
- Illegal opcode: `IR_Data`=0xF8000000 → HALT, `illegal`=1, `retired` unchanged.
- Reset mid-instruction and counter wrap:
  - Reset: `clr` pulsed during T4 → immediately IDLE, `Z_in`=0, `retired`=0.
  - Wrap: with `RETIRE_W`=2, 5 NOPs → `retired`=1.
